// File: rtl/add_stream_ctrl_if.sv
// Operand-in / result-out stream handshake for add_stream_ctrl.
interface add_stream_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_sum;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/add_stream_ctrl.sv
// Buffers operand pairs, feeds an external 4-bit adder from the FIFO head and
// registers {cout, sum} into a valid/ready output stage with a carry counter.
module add_stream_ctrl #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  add_stream_ctrl_if.slave   s,
  output logic [3:0]         add_a,
  output logic [3:0]         add_b,
  input  logic [3:0]         add_x,
  input  logic               add_cout,
  output logic [CNT_W-1:0]   carry_cnt,
  output logic               busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
  } pair_t;

  pair_t         mem [FIFO_DEPTH];
  pair_t         head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, push, pop;
  logic          ov_q;
  logic [4:0]    sum_q;

  assign empty      = (count == '0);
  // Ready comes from the occupancy register alone, so a pop on the same edge
  // never opens a slot for a full FIFO.
  assign s.in_ready = (count < DEPTH_C);
  assign push       = s.in_valid && s.in_ready;
  assign pop        = !empty && (!ov_q || s.out_ready);

  assign head  = mem[rd_ptr];
  assign add_a = empty ? 4'b0000 : head.a;
  assign add_b = empty ? 4'b0000 : head.b;

  assign s.out_valid = ov_q;
  assign s.out_sum   = sum_q;
  assign busy        = !empty || ov_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: s.in_a, b: s.in_b};
  end

  // Pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q      <= 1'b0;
      sum_q     <= 5'b00000;
      carry_cnt <= '0;
    end else begin
      if (pop) begin
        ov_q  <= 1'b1;
        sum_q <= {add_cout, add_x};
      end else if (s.out_ready) begin
        ov_q  <= 1'b0;
      end
      if (pop && add_cout && (carry_cnt != {CNT_W{1'b1}}))
        carry_cnt <= carry_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_add_stream_ctrl.sv
// Self-checking bench: hand tables, corner sequences and random traffic
// against a queue-based model of the buffered adder stream.
module tb_add_stream_ctrl;
  localparam int DEPTH = 2;
  localparam int CW    = 8;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  add_stream_ctrl_if bus();
  logic [3:0]    add_a, add_b, add_x;
  logic          add_cout;
  logic [CW-1:0] carry_cnt;
  logic          busy;

  // External combinational adder
  assign {add_cout, add_x} = {1'b0, add_a} + {1'b0, add_b};

  add_stream_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (bus),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_x     (add_x),
    .add_cout  (add_cout),
    .carry_cnt (carry_cnt),
    .busy      (busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] mq[$];
  bit         m_ov;
  int         m_sum;
  int         m_cnt;
  bit         cur_iv, cur_ordy;
  logic [3:0] cur_a, cur_b;

  typedef struct {
    bit         iv;
    logic [3:0] a;
    logic [3:0] b;
    bit         ordy;
    bit         ov;
    logic [4:0] sum;
    bit         irdy;
    int         cnt;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ov = 0;
    m_sum = 0;
    m_cnt = 0;
  endtask

  task automatic set_in(input bit iv, input logic [3:0] a, input logic [3:0] b, input bit ordy);
    cur_iv = iv; cur_a = a; cur_b = b; cur_ordy = ordy;
    bus.in_valid  = iv;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = ordy;
  endtask

  // Compare all visible state with the model (between edges).
  task automatic obs();
    int ea, eb;
    ea = 0; eb = 0;
    if (mq.size() != 0) begin
      ea = int'(mq[0][7:4]);
      eb = int'(mq[0][3:0]);
    end
    chk("in_ready",  32'(bus.in_ready),  32'(mq.size() < DEPTH));
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    chk("out_sum",   32'(bus.out_sum),   32'(m_sum));
    chk("add_a",     32'(add_a),         32'(ea));
    chk("add_b",     32'(add_b),         32'(eb));
    chk("carry_cnt", 32'(carry_cnt),     32'(m_cnt));
    chk("busy",      32'(busy),          32'(mq.size() != 0 || m_ov));
  endtask

  // Apply the transfer rules for the coming edge, then move to the next negedge.
  task automatic adv();
    bit cap, psh;
    logic [7:0] h;
    cap = (mq.size() != 0) && (!m_ov || cur_ordy);
    psh = cur_iv && (mq.size() < DEPTH);
    if (cap) begin
      h = mq.pop_front();
      m_sum = int'(h[7:4]) + int'(h[3:0]);
      m_ov = 1;
      if (m_sum > 15 && m_cnt < CMAX) m_cnt++;
    end else if (cur_ordy) begin
      m_ov = 0;
    end
    if (psh) mq.push_back({cur_a, cur_b});
    @(negedge clk);
  endtask

  task automatic cyc(input bit iv, input logic [3:0] a, input logic [3:0] b, input bit ordy);
    set_in(iv, a, b, ordy);
    obs();
    adv();
  endtask

  initial begin
    tbl[0]  = '{1'b1, 4'h8, 4'h8, 1'b1, 1'b0, 5'h00, 1'b1, 0};
    tbl[1]  = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 5'h00, 1'b1, 0};
    tbl[2]  = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 5'h10, 1'b1, 1};
    tbl[3]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 5'h10, 1'b1, 1};
    tbl[4]  = '{1'b1, 4'hF, 4'h1, 1'b0, 1'b0, 5'h10, 1'b1, 1};
    tbl[5]  = '{1'b1, 4'h3, 4'h4, 1'b0, 1'b0, 5'h10, 1'b1, 1};
    tbl[6]  = '{1'b1, 4'h2, 4'h2, 1'b0, 1'b1, 5'h10, 1'b1, 2};
    tbl[7]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 5'h10, 1'b0, 2};
    tbl[8]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 5'h10, 1'b0, 2};
    tbl[9]  = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 5'h10, 1'b0, 2};
    tbl[10] = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 5'h07, 1'b1, 2};
    tbl[11] = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 5'h04, 1'b1, 2};
    tbl[12] = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 5'h04, 1'b1, 2};

    rst_n = 1'b0;
    set_in(0, 4'h0, 4'h0, 0);
    model_reset();
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_sum",   32'(bus.out_sum),   32'd0);
    chk("rst_busy",      32'(busy),          32'd0);
    #3 rst_n = 1'b1;

    // Single pair, then backpressure with three queued pairs
    for (int i = 0; i < 13; i++) begin
      set_in(tbl[i].iv, tbl[i].a, tbl[i].b, tbl[i].ordy);
      obs();
      chk($sformatf("tbl%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_out_sum", i),   32'(bus.out_sum),   32'(tbl[i].sum));
      chk($sformatf("tbl%0d_in_ready", i),  32'(bus.in_ready),  32'(tbl[i].irdy));
      chk($sformatf("tbl%0d_carry_cnt", i), 32'(carry_cnt),     32'(tbl[i].cnt));
      adv();
    end

    // Streaming i+i, one result per cycle
    for (int j = 0; j < 18; j++) begin
      set_in(j < 16, 4'(j), 4'(j), 1);
      obs();
      if (j >= 2) begin
        chk($sformatf("stream%0d_valid", j - 2), 32'(bus.out_valid), 32'd1);
        chk($sformatf("stream%0d_sum", j - 2),   32'(bus.out_sum),   32'(2 * (j - 2)));
      end
      if (j == 17) chk("stream_carry_cnt", 32'(carry_cnt), 32'd10);
      adv();
    end

    // Full FIFO with simultaneous pop and offered push
    cyc(1, 4'h1, 4'h1, 0);
    cyc(1, 4'h2, 4'h2, 0);
    cyc(1, 4'h3, 4'h3, 0);
    set_in(1, 4'h4, 4'h4, 1); obs();
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_sum0",     32'(bus.out_sum),  32'd2);
    adv();
    set_in(1, 4'h4, 4'h4, 1); obs();
    chk("after_pop_in_ready", 32'(bus.in_ready), 32'd1);
    chk("full_sum1",          32'(bus.out_sum),  32'd4);
    adv();
    set_in(0, 4'h0, 4'h0, 1); obs();
    chk("full_sum2", 32'(bus.out_sum), 32'd6);
    adv();
    set_in(0, 4'h0, 4'h0, 1); obs();
    chk("full_sum3", 32'(bus.out_sum), 32'd8);
    adv();
    set_in(0, 4'h0, 4'h0, 1); obs();
    chk("full_drained", 32'(bus.out_valid), 32'd0);
    adv();

    // Random traffic against the model
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), $urandom_range(0, 2) != 0);

    // Carry counter saturation
    for (int k = 0; k < 300; k++) cyc(1, 4'hF, 4'hF, 1);
    for (int k = 0; k < 3; k++)   cyc(0, 4'h0, 4'h0, 1);
    chk("sat_cnt", 32'(carry_cnt), 32'd255);
    for (int k = 0; k < 5; k++)   cyc(1, 4'hF, 4'hF, 1);
    for (int k = 0; k < 3; k++)   cyc(0, 4'h0, 4'h0, 1);
    chk("sat_hold", 32'(carry_cnt), 32'd255);

    // Asynchronous reset while full and holding a result
    for (int k = 0; k < 3; k++) cyc(1, 4'h1, 4'h2, 0);
    chk("pre_rst_full", 32'(bus.in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("arst_carry_cnt", 32'(carry_cnt),     32'd0);
    chk("arst_busy",      32'(busy),          32'd0);
    chk("arst_add_a",     32'(add_a),         32'd0);
    chk("arst_out_sum",   32'(bus.out_sum),   32'd0);
    model_reset();
    set_in(0, 4'h0, 4'h0, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    cyc(1, 4'h5, 4'h6, 1);
    set_in(0, 4'h0, 4'h0, 1); obs();
    chk("post_rst_lat0", 32'(bus.out_valid), 32'd0);
    adv();
    set_in(0, 4'h0, 4'h0, 1); obs();
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("post_rst_sum",   32'(bus.out_sum),   32'h0B);
    adv();
    cyc(0, 4'h0, 4'h0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/add_stream_ctrl.md
ADD_STREAM_CTRL -- requirements
Module: add_stream_ctrl

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 2, the operand buffer depth; legal values are powers of two and at least 2.
REQ-002 The block SHALL have parameter CNT_W, default 8, the width of the carry-event counter.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1 bit: an operand pair is offered.
REQ-006 Port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-007 Port in_a, input, 4 bits: operand A.
REQ-008 Port in_b, input, 4 bits: operand B.
REQ-009 Port add_a, output, 4 bits: operand A driven to the external combinational 4-bit adder.
REQ-010 Port add_b, output, 4 bits: operand B driven to the external adder.
REQ-011 Port add_x, input, 4 bits: sum returned by the external adder.
REQ-012 Port add_cout, input, 1 bit: carry-out returned by the external adder.
REQ-013 Port out_valid, output, 1 bit: out_sum holds a result.
REQ-014 Port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-015 Port out_sum, output, 5 bits: registered result {add_cout, add_x}.
REQ-016 Port carry_cnt, output, CNT_W bits: count of results captured with carry-out set.
REQ-017 Port busy, output, 1 bit: the buffer is non-empty or out_valid is high.

Function
REQ-018 An input transfer SHALL occur on a rising edge where in_valid && in_ready; an output transfer SHALL occur on a rising edge where out_valid && out_ready.
REQ-019 Accepted pairs SHALL be stored in a FIFO of FIFO_DEPTH entries, in arrival order.
REQ-020 in_ready SHALL be high exactly when the FIFO count is less than FIFO_DEPTH, decoded from registered state only; it SHALL NOT depend combinationally on out_ready.
REQ-021 add_a/add_b SHALL be driven combinationally from the FIFO head entry; they SHALL be 4'b0000 when the FIFO is empty.
REQ-022 A capture SHALL occur on a rising edge where the FIFO is non-empty and the output register is free, i.e. (!out_valid || out_ready).
REQ-023 On capture: out_sum <= {add_cout, add_x}, out_valid <= 1, and the head entry is popped.
REQ-024 If out_valid && out_ready at an edge with no capture, out_valid SHALL go to 0 and out_sum SHALL hold its value.
REQ-025 Latency: a pair accepted at edge k into an empty block SHALL appear with out_valid=1 after edge k+1.
REQ-026 Throughput SHALL be one result per cycle while in_valid and out_ready are held high.
REQ-027 When a push and a pop occur on the same edge, the count SHALL be unchanged, data SHALL be preserved, and the pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 When the FIFO is full, in_ready SHALL be 0 and no push SHALL occur, even if a pop happens on the same edge; a push onto a full FIFO SHALL never corrupt data.
REQ-029 Backpressure: while out_valid=1 and out_ready=0, out_sum, the head entry and add_a/add_b SHALL remain stable.
REQ-030 carry_cnt SHALL increment by 1 on each capture where add_cout=1, and SHALL saturate at 2^CNT_W-1.
REQ-031 Sum arithmetic SHALL be taken from the adder only; the block SHALL NOT recompute A+B internally.

Reset
REQ-032 Asserting rst_n=0 SHALL immediately clear the FIFO (count 0, pointers 0), out_valid=0, out_sum=5'b00000 and carry_cnt=0; in_ready SHALL be 1, busy 0, and add_a/add_b 0.
REQ-033 A reset asserted mid-stream SHALL discard all buffered and pending results; the first pair accepted after release SHALL be handled as in REQ-025.
REQ-034 No transfer SHALL occur on the first rising edge after rst_n rises if that edge coincides with the deassertion.

Verification
REQ-035 Single pair: in_a=4'b1000, in_b=4'b1000, out_ready=1 -> out_sum=5'b10000 one cycle after acceptance; carry_cnt=1.
REQ-036 Streaming: 16 pairs A=i, B=i (i=0..15), out_ready=1 -> 16 results in order, out_sum=2i, no gaps, carry_cnt=8.
REQ-037 Backpressure: out_ready=0, push 0xF+0x1, then 0x3+0x4, then 0x2+0x2 -> out_sum stuck at 5'b10000, in_ready=0 after the FIFO fills; on release, results 10000, 00111, 00100 in order.
REQ-038 Saturation: 300 pairs 0xF+0xF with CNT_W=8 -> carry_cnt=255 and holds.
REQ-039 Reset mid-operation: rst_n=0 while full with out_valid=1 -> out_valid=0, in_ready=1, carry_cnt=0 immediately (asynchronously); the next pair 0x5+0x6 -> out_sum=5'b01011.
REQ-040 Full push/pop: a full FIFO with out_ready=1 and in_valid=1 -> no push on the pop edge, a push on the next edge, and no data loss or duplication across pointer wrap.
